// File: rtl/carbon_csr_boot_seq.sv
// Boot sequencer: replays a CSR init table through a CSR master,
// optionally verifies each write, then releases the held cores.
module carbon_csr_boot_seq #(
  parameter int NUM_ENTRIES = 1,
  parameter int NUM_CORES = 1,
  parameter logic [NUM_ENTRIES*32-1:0] ENTRY_ADDR =
    {NUM_ENTRIES{32'h0}},
  parameter logic [NUM_ENTRIES*32-1:0] ENTRY_DATA =
    {NUM_ENTRIES{32'h4}},
  parameter int VERIFY = 0,
  parameter int TIMEOUT = 255,
  parameter logic [NUM_CORES-1:0] RELEASE_MASK = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 m_start,
  output logic                 m_write,
  output logic [31:0]          m_addr,
  output logic [31:0]          m_wdata,
  output logic [3:0]           m_wstrb,
  output logic [1:0]           m_priv,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_fault,
  input  logic [31:0]          m_rdata,
  output logic [NUM_CORES-1:0] halt_req,
  output logic [NUM_CORES-1:0] run_req,
  output logic                 boot_done,
  output logic                 boot_fault,
  output logic [3:0]           fault_index,
  output logic [1:0]           fault_code
);

  typedef enum logic [3:0] {
    RST_WAIT, ISSUE, WAIT_W, ISSUE_R, WAIT_R,
    NEXT, RELEASE, DONE, FAULT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_idx;
  logic [15:0] r_cnt;
  logic [1:0]  r_code;
  logic [1:0]  w_code;
  logic        w_last;
  logic        w_tmo;
  logic        w_wait;
  logic [31:0] w_data;

  logic [31:0] w_addr_tab [16];
  logic [31:0] w_data_tab [16];

  // Unpack the table; unused slots read as zero.
  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_ENTRIES) begin : g_on
      assign w_addr_tab[g] = ENTRY_ADDR[g*32 +: 32];
      assign w_data_tab[g] = ENTRY_DATA[g*32 +: 32];
    end else begin : g_off
      assign w_addr_tab[g] = '0;
      assign w_data_tab[g] = '0;
    end
  end

  assign w_data  = w_data_tab[r_idx];
  assign m_addr  = w_addr_tab[r_idx];
  assign m_wdata = w_data;
  assign m_wstrb = 4'hF;
  assign m_priv  = 2'd1;

  assign w_last = (r_idx == 4'(NUM_ENTRIES - 1));
  assign w_tmo  = (r_cnt == 16'(TIMEOUT - 1));
  assign w_wait = (r_state == WAIT_W) ||
                  (r_state == WAIT_R);

  // State and fault-cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_WAIT;
      r_code  <= 2'd0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
    end
  end

  // Entry index and per-request timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 4'd0;
      r_cnt <= 16'd0;
    end else begin
      if (r_state == NEXT && !w_last)
        r_idx <= r_idx + 4'd1;
      if (m_start)
        r_cnt <= 16'd0;
      else if (w_wait)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // Next state; m_done wins over a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    w_code = r_code;
    unique case (r_state)
      RST_WAIT: w_next = ISSUE;
      ISSUE:    if (!m_busy) w_next = WAIT_W;
      ISSUE_R:  if (!m_busy) w_next = WAIT_R;
      WAIT_W: begin
        if (m_done) begin
          if (m_fault) begin
            w_next = FAULT;
            w_code = 2'd1;
          end else begin
            w_next = (VERIFY != 0) ? ISSUE_R : NEXT;
          end
        end else if (w_tmo) begin
          w_next = FAULT;
          w_code = 2'd2;
        end
      end
      WAIT_R: begin
        if (m_done) begin
          if (m_fault) begin
            w_next = FAULT;
            w_code = 2'd1;
          end else if (m_rdata != w_data) begin
            w_next = FAULT;
            w_code = 2'd3;
          end else begin
            w_next = NEXT;
          end
        end else if (w_tmo) begin
          w_next = FAULT;
          w_code = 2'd2;
        end
      end
      NEXT:    w_next = w_last ? RELEASE : ISSUE;
      RELEASE: w_next = DONE;
      DONE:    w_next = DONE;
      FAULT:   w_next = FAULT;
      default: w_next = RST_WAIT;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    m_start     = 1'b0;
    m_write     = 1'b1;
    halt_req    = '1;
    run_req     = '0;
    boot_done   = 1'b0;
    boot_fault  = 1'b0;
    fault_index = 4'd0;
    fault_code  = r_code;
    unique case (r_state)
      ISSUE:   m_start = !m_busy;
      ISSUE_R: begin
        m_start = !m_busy;
        m_write = 1'b0;
      end
      WAIT_R:  m_write = 1'b0;
      RELEASE: begin
        halt_req  = ~RELEASE_MASK;
        run_req   = RELEASE_MASK;
        boot_done = 1'b1;
      end
      DONE: begin
        halt_req  = ~RELEASE_MASK;
        boot_done = 1'b1;
      end
      FAULT: begin
        boot_fault  = 1'b1;
        fault_index = r_idx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_carbon_csr_boot_seq.sv
// Bench for carbon_csr_boot_seq: CSR master model, request
// scoreboard, outcome vector table and hand-written corner runs.
module tb_carbon_csr_boot_seq;

  localparam int NE = 3;
  localparam int NC = 4;
  localparam int TMO = 10;
  localparam logic [31:0] A0 = 32'h0000_0300;
  localparam logic [31:0] A1 = 32'h0000_0304;
  localparam logic [31:0] A2 = 32'h0000_0308;
  localparam logic [31:0] D0 = 32'hA5A5_0001;
  localparam logic [31:0] D1 = 32'hB0B0_0002;
  localparam logic [31:0] D2 = 32'hC0DE_0003;
  localparam logic [3:0]  RMASK = 4'b0101;

  logic          clk;
  logic          rst_n;
  logic          m_start;
  logic          m_write;
  logic [31:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_priv;
  logic          m_busy;
  logic          m_done;
  logic          m_fault;
  logic [31:0]   m_rdata;
  logic [NC-1:0] halt_req;
  logic [NC-1:0] run_req;
  logic          boot_done;
  logic          boot_fault;
  logic [3:0]    fault_index;
  logic [1:0]    fault_code;

  carbon_csr_boot_seq #(
    .NUM_ENTRIES (NE),
    .NUM_CORES   (NC),
    .ENTRY_ADDR  ({A2, A1, A0}),
    .ENTRY_DATA  ({D2, D1, D0}),
    .VERIFY      (1),
    .TIMEOUT     (TMO),
    .RELEASE_MASK(RMASK)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_start    (m_start),
    .m_write    (m_write),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_priv     (m_priv),
    .m_busy     (m_busy),
    .m_done     (m_done),
    .m_fault    (m_fault),
    .m_rdata    (m_rdata),
    .halt_req   (halt_req),
    .run_req    (run_req),
    .boot_done  (boot_done),
    .boot_fault (boot_fault),
    .fault_index(fault_index),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] taddr(input int e);
    case (e)
      0: return A0;
      1: return A1;
      default: return A2;
    endcase
  endfunction

  function automatic logic [31:0] tdata(input int e);
    case (e)
      0: return D0;
      1: return D1;
      default: return D2;
    endcase
  endfunction

  // CSR master model knobs (-1 = never)
  int lat;
  int fault_at;
  int bad_at;
  int hang_at;
  int busy_left;

  int          pend;
  logic        pend_f;
  logic [31:0] pend_rd;
  logic        smp_start;
  logic        smp_write;
  logic [31:0] smp_addr;

  // Model: m_done arrives lat cycles after the start edge.
  initial begin : model
    int e;
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_fault = 1'b0;
    m_rdata = '0;
    pend    = 0;
    forever begin
      @(negedge clk);
      smp_start = m_start;
      smp_write = m_write;
      smp_addr  = m_addr;
      @(posedge clk);
      #1;
      m_done  = 1'b0;
      m_fault = 1'b0;
      if (!rst_n) begin
        pend   = 0;
        m_busy = (busy_left > 0);
      end else begin
        if (busy_left > 0) begin
          m_busy = 1'b1;
          busy_left--;
        end else begin
          m_busy = 1'b0;
        end
        if (smp_start) begin
          e = int'((smp_addr - 32'h300) >> 2);
          if (smp_write && e == hang_at) begin
            pend = 0;
          end else begin
            pend    = lat;
            pend_f  = smp_write && (e == fault_at);
            pend_rd = tdata(e);
            if (!smp_write && e == bad_at)
              pend_rd = pend_rd ^ 32'h1;
          end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            m_done  = 1'b1;
            m_fault = pend_f;
            m_rdata = pend_rd;
          end
        end
      end
    end
  end

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t exp_q [$];
  req_t mon_r;
  int   n_run;
  logic [NC-1:0] last_run;

  task automatic push_exp(input int stop_e,
                          input int stop_rd);
    exp_q.delete();
    for (int e = 0; e < stop_e; e++) begin
      exp_q.push_back('{1'b1, taddr(e), tdata(e)});
      exp_q.push_back('{1'b0, taddr(e), tdata(e)});
    end
    if (stop_e < NE)
      exp_q.push_back('{1'b1, taddr(stop_e), tdata(stop_e)});
    if (stop_e < NE && stop_rd != 0)
      exp_q.push_back('{1'b0, taddr(stop_e), tdata(stop_e)});
  endtask

  // Scoreboard: each start pulse pops one expected request.
  always @(negedge clk) begin
    if (rst_n && m_start) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_start: got addr %0h expected none",
                 m_addr);
      end else begin
        mon_r = exp_q.pop_front();
        chk("req_write", 32'(m_write), 32'(mon_r.w));
        chk("req_addr", m_addr, mon_r.a);
        if (mon_r.w)
          chk("req_wdata", m_wdata, mon_r.d);
        chk("req_wstrb", 32'(m_wstrb), 32'hF);
        chk("req_priv", 32'(m_priv), 32'd1);
      end
    end
    if (rst_n && run_req != '0) begin
      n_run++;
      last_run = run_req;
    end
  end

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_halt"}, 32'(halt_req), 32'hF);
    chk({tag, "_run"}, 32'(run_req), 32'h0);
    chk({tag, "_start"}, 32'(m_start), 32'h0);
    chk({tag, "_done"}, 32'(boot_done), 32'h0);
    chk({tag, "_fault"}, 32'(boot_fault), 32'h0);
    chk({tag, "_fidx"}, 32'(fault_index), 32'h0);
    chk({tag, "_fcode"}, 32'(fault_code), 32'h0);
  endtask

  task automatic reset_on();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst_vals("rst");
    n_run = 0;
  endtask

  task automatic reset_off();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_end();
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (boot_done || boot_fault) fin = 1'b1;
    end
    chk("end_reached", 32'(fin), 32'h1);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    int         lat;
    int         fault_at;
    int         bad_at;
    int         hang_at;
    int         stop_e;
    int         stop_rd;
    logic       e_done;
    logic       e_fault;
    logic [3:0] e_idx;
    logic [1:0] e_code;
    logic [3:0] e_halt;
    int         e_runs;
  } vec_t;

  vec_t v [8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    bit fin;
    int nb;
    n_chk     = 0;
    n_fail    = 0;
    n_run     = 0;
    last_run  = '0;
    busy_left = 0;
    lat       = 2;
    fault_at  = -1;
    bad_at    = -1;
    hang_at   = -1;
    rst_n     = 1'b0;

    v[0] = '{2, -1, -1, -1, 3, 0, 1'b1, 1'b0,
             4'd0, 2'd0, 4'b1010, 1};
    v[1] = '{1, -1, 1, -1, 1, 1, 1'b0, 1'b1,
             4'd1, 2'd3, 4'hF, 0};
    v[2] = '{2, 0, -1, -1, 0, 0, 1'b0, 1'b1,
             4'd0, 2'd1, 4'hF, 0};
    v[3] = '{3, -1, -1, 2, 2, 0, 1'b0, 1'b1,
             4'd2, 2'd2, 4'hF, 0};
    v[4] = '{10, -1, -1, -1, 3, 0, 1'b1, 1'b0,
             4'd0, 2'd0, 4'b1010, 1};
    v[5] = '{11, -1, -1, -1, 0, 0, 1'b0, 1'b1,
             4'd0, 2'd2, 4'hF, 0};
    v[6] = '{4, 2, -1, -1, 2, 0, 1'b0, 1'b1,
             4'd2, 2'd1, 4'hF, 0};
    v[7] = '{5, -1, 0, -1, 0, 1, 1'b0, 1'b1,
             4'd0, 2'd3, 4'hF, 0};

    for (int k = 0; k < 8; k++) begin
      lat      = v[k].lat;
      fault_at = v[k].fault_at;
      bad_at   = v[k].bad_at;
      hang_at  = v[k].hang_at;
      reset_on();
      push_exp(v[k].stop_e, v[k].stop_rd);
      reset_off();
      run_to_end();
      chk("v_boot_done", 32'(boot_done), 32'(v[k].e_done));
      chk("v_boot_fault", 32'(boot_fault),
          32'(v[k].e_fault));
      chk("v_fault_code", 32'(fault_code),
          32'(v[k].e_code));
      chk("v_halt_req", 32'(halt_req), 32'(v[k].e_halt));
      chk("v_run_pulses", 32'(n_run), 32'(v[k].e_runs));
      if (v[k].e_runs > 0)
        chk("v_run_bits", 32'(last_run), 32'(RMASK));
      if (v[k].e_fault)
        chk("v_fault_index", 32'(fault_index),
            32'(v[k].e_idx));
      chk("v_reqs_left", 32'(exp_q.size()), 32'h0);
    end

    // Timeout lands exactly TMO edges after the start edge.
    lat      = 2;
    fault_at = -1;
    bad_at   = -1;
    hang_at  = 0;
    reset_on();
    push_exp(0, 0);
    reset_off();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_start) seen = 1'b1;
    end
    chk("tmo_start_seen", 32'(seen), 32'h1);
    repeat (TMO) @(negedge clk);
    chk("tmo_before", 32'(boot_fault), 32'h0);
    @(negedge clk);
    chk("tmo_at", 32'(boot_fault), 32'h1);
    chk("tmo_code", 32'(fault_code), 32'd2);
    chk("tmo_fidx", 32'(fault_index), 32'd0);

    // Busy hold at start, then reset during entry 1 write.
    hang_at = -1;
    reset_on();
    busy_left = 5;
    push_exp(1, 0);
    reset_off();
    nb  = 0;
    fin = 1'b0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (m_busy) begin
        nb++;
        chk("busy_no_start", 32'(m_start), 32'h0);
      end else begin
        chk("start_after_busy", 32'(m_start), 32'h1);
        fin = 1'b1;
      end
    end
    chk("busy_seen", 32'(nb >= 5), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (m_start && m_write && m_addr == A1)
        seen = 1'b1;
    end
    chk("mid_w1_seen", 32'(seen), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst_vals("mid");
    chk("mid_reqs_left", 32'(exp_q.size()), 32'h0);
    push_exp(3, 0);
    n_run = 0;
    repeat (2) @(negedge clk);
    reset_off();
    run_to_end();
    chk("mid_boot_done", 32'(boot_done), 32'h1);
    chk("mid_halt_req", 32'(halt_req), 32'b1010);
    chk("mid_run_pulses", 32'(n_run), 32'h1);
    chk("mid_reqs_after", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/carbon_csr_boot_seq.md
CARBON_CSR_BOOT_SEQ -- requirements
Module: carbon_csr_boot_seq

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 1: number of CSR init writes in the table, range 1..16.
REQ-002 SHALL have parameter NUM_CORES, default 1: number of cores held halted, range 1..8.
REQ-003 SHALL have parameter ENTRY_ADDR, default {32'h0}: packed NUM_ENTRIES x 32-bit CSR addresses; entry 0 is in the LSBs.
REQ-004 SHALL have parameter ENTRY_DATA, default {32'h4}: packed NUM_ENTRIES x 32-bit write data.
REQ-005 SHALL have parameter VERIFY, default 0: when 1, each write is followed by a readback compare.
REQ-006 SHALL have parameter TIMEOUT, default 255: maximum cycles allowed from start to done_pulse, range 1..65535.
REQ-007 SHALL have parameter RELEASE_MASK, default all-ones: the cores released on success.
REQ-008 clk  in  1  system clock; one clock domain; all state updates on the rising edge.
REQ-009 rst_n  in  1  asynchronous, active-low reset.
REQ-010 m_start  out  1  one-cycle request pulse to the CSR master.
REQ-011 m_write  out  1  1 = write, 0 = readback.
REQ-012 m_addr / m_wdata  out  32 / 32  current entry address and data.
REQ-013 m_wstrb  out  4  constant 4'hF.
REQ-014 m_priv  out  2  constant 2'd1.
REQ-015 m_busy / m_done / m_fault  in  1 each  CSR master status; m_done is a one-cycle pulse; m_fault is valid in the m_done cycle.
REQ-016 m_rdata  in  32  readback data, valid in the m_done cycle.
REQ-017 halt_req  out  NUM_CORES  per-core debug halt request.
REQ-018 run_req  out  NUM_CORES  per-core one-cycle run pulse.
REQ-019 boot_done  out  1  sticky: sequence completed successfully.
REQ-020 boot_fault  out  1  sticky: sequence aborted.
REQ-021 fault_index  out  4  index of the failing entry.
REQ-022 fault_code  out  2  failure cause: 1 = bus fault, 2 = timeout, 3 = verify mismatch.

Function
REQ-023 SHALL implement states RST_WAIT, ISSUE, WAIT_W, ISSUE_R, WAIT_R, NEXT, RELEASE, DONE, FAULT.
REQ-024 SHALL leave RST_WAIT for ISSUE in the first cycle after reset deassertion; index = 0.
REQ-025 ISSUE: when m_busy=0, SHALL assert m_start=1 with m_write=1 for exactly one cycle, then enter WAIT_W; while m_busy=1, SHALL hold in ISSUE with m_start=0.
REQ-026 SHALL drive m_addr and m_wdata from table[index] continuously; they are stable from ISSUE through done.
REQ-027 SHALL reset the timeout counter to 0 on each m_start and increment it each WAIT cycle; reaching TIMEOUT with no m_done SHALL enter FAULT with code 2.
REQ-028 On m_done with m_fault=1, SHALL enter FAULT with code 1.
REQ-029 On m_done with m_fault=0, SHALL enter ISSUE_R if VERIFY=1, otherwise NEXT.
REQ-030 ISSUE_R and WAIT_R SHALL mirror ISSUE and WAIT_W with m_write=0.
REQ-031 In WAIT_R, m_rdata != ENTRY_DATA[index] SHALL enter FAULT with code 3; a match SHALL enter NEXT.
REQ-032 If m_done and the timeout fire in the same cycle, m_done SHALL take priority.
REQ-033 NEXT: index == NUM_ENTRIES-1 SHALL enter RELEASE; otherwise index increments and the FSM returns to ISSUE.
REQ-034 RELEASE: for cores in RELEASE_MASK, SHALL clear halt_req and pulse run_req for one cycle; SHALL set boot_done; SHALL enter DONE.
REQ-035 DONE and FAULT SHALL be terminal until reset; m_start SHALL stay 0 in both.
REQ-036 FAULT: all halt_req bits SHALL remain 1; run_req SHALL stay 0; boot_fault=1; fault_index = index.
REQ-037 An m_done arriving outside WAIT_W/WAIT_R SHALL be ignored.
REQ-038 boot_done and boot_fault SHALL never both be 1.

Reset
REQ-039 Reset values: halt_req all-ones, run_req 0, m_start 0, boot_done 0, boot_fault 0, fault_index 0, fault_code 0, state RST_WAIT, index 0.
REQ-040 Reset asserted mid-sequence SHALL return all outputs to reset values immediately and restart from entry 0 after release.

Verification
REQ-041 NUM_ENTRIES=3, VERIFY=0, CSR model with done 2 cycles after start -> exactly 3 start pulses at addresses e0..e2; one run_req pulse; boot_done=1; halt_req=0.
REQ-042 VERIFY=1, entry 1 readback returns data^1 -> boot_fault=1, fault_index=1, fault_code=3, halt_req all-ones, no run_req.
REQ-043 TIMEOUT=10, model never returns done -> FAULT with code 2 exactly 10 cycles after start.
REQ-044 m_fault=1 on entry 0 -> fault_code=1, fault_index=0; no further m_start.
REQ-045 NUM_CORES=4, RELEASE_MASK=4'b0101 -> halt_req=4'b1010 after boot; run_req pulses on bits 0 and 2 only.
REQ-046 m_busy held high for 5 cycles at start -> no m_start until m_busy=0; reset during WAIT_W of entry 1 -> after reset, the sequence restarts from entry 0.
